// File: rtl/wheel_setpoint_ramp.sv
// Wheel setpoint slew-rate limiter: ramps a sign-magnitude speed output toward a
// latched target by at most STEP per control tick, always passing through +0 on a
// direction reversal.
// Optional feature macro: WHEEL_SETPOINT_RAMP_ESTOP_EN adds a synchronous
// emergency-stop input that forces output and target to +0.
module wheel_setpoint_ramp #(
    parameter int unsigned          N_WIDTH = 17,
    parameter int unsigned          Q_WIDTH = 8,
    // 20.0 rad/s in Q_WIDTH fixed point
    parameter logic [N_WIDTH-2:0]   MAX_MAG = (N_WIDTH-1)'(20 << Q_WIDTH)
) (
    input  logic                    WHEEL_SETPOINT_RAMP_CLOCK,
    input  logic                    WHEEL_SETPOINT_RAMP_RESET_InLow,
    input  logic [N_WIDTH-1:0]      WHEEL_SETPOINT_RAMP_TARGET_InBus,
    input  logic                    WHEEL_SETPOINT_RAMP_TARGETVALID_In,
    input  logic [N_WIDTH-2:0]      WHEEL_SETPOINT_RAMP_STEP_InBus,
    input  logic                    WHEEL_SETPOINT_RAMP_TICK_In,
`ifdef WHEEL_SETPOINT_RAMP_ESTOP_EN
    input  logic                    WHEEL_SETPOINT_RAMP_ESTOP_In,
`endif
    output logic [N_WIDTH-1:0]      WHEEL_SETPOINT_RAMP_W_OutBus,
    output logic                    WHEEL_SETPOINT_RAMP_ATTARGET_Out,
    output logic                    WHEEL_SETPOINT_RAMP_REVERSING_Out
);

    localparam int unsigned M_WIDTH = N_WIDTH - 1;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        ACCEL   = 2'd1,
        DECEL   = 2'd2,
        REVERSE = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [N_WIDTH-1:0]   w_q, w_d;
    logic [N_WIDTH-1:0]   tgt_q, tgt_d;

    logic [M_WIDTH-1:0]   tin_mag;
    logic [M_WIDTH-1:0]   tin_clamp;
    logic                 tin_sign;

    logic                 cur_sign, tgt_sign;
    logic [M_WIDTH-1:0]   cur_mag, tgt_mag, step;
    logic [N_WIDTH-1:0]   sum;
    logic [M_WIDTH-1:0]   acc_mag, dec_raw, dec_mag;
    logic                 same_dir;

    assign step     = WHEEL_SETPOINT_RAMP_STEP_InBus;
    assign cur_sign = w_q[N_WIDTH-1];
    assign cur_mag  = w_q[M_WIDTH-1:0];
    assign tgt_sign = tgt_q[N_WIDTH-1];
    assign tgt_mag  = tgt_q[M_WIDTH-1:0];

    // Incoming target: clamp magnitude and fold -0 onto +0
    always_comb begin
        tin_mag   = WHEEL_SETPOINT_RAMP_TARGET_InBus[M_WIDTH-1:0];
        tin_clamp = (tin_mag > MAX_MAG) ? MAX_MAG : tin_mag;
        tin_sign  = WHEEL_SETPOINT_RAMP_TARGET_InBus[N_WIDTH-1] & (tin_mag != '0);
    end

    // Saturating step arithmetic; the widened sum cannot wrap
    always_comb begin
        sum      = N_WIDTH'(cur_mag) + N_WIDTH'(step);
        acc_mag  = (sum > N_WIDTH'(tgt_mag)) ? tgt_mag : sum[M_WIDTH-1:0];
        dec_raw  = (step >= cur_mag) ? '0 : (cur_mag - step);
        dec_mag  = (dec_raw < tgt_mag) ? tgt_mag : dec_raw;
        same_dir = (cur_sign == tgt_sign) || (cur_mag == '0);
    end

    // Next-state: target latch, per-tick ramp step and mode selection
    always_comb begin
        logic               nxt_sign;
        logic [M_WIDTH-1:0] nxt_mag;
        state_e             mode;

        w_d      = w_q;
        tgt_d    = tgt_q;
        state_d  = state_q;
        nxt_sign = cur_sign;
        nxt_mag  = cur_mag;
        mode     = HOLD;

        if (WHEEL_SETPOINT_RAMP_TARGETVALID_In) begin
            tgt_d = {tin_sign, tin_clamp};
        end

        // The step always uses the target held before this edge
        if (WHEEL_SETPOINT_RAMP_TICK_In) begin
            if (w_q == tgt_q) begin
                mode = HOLD;
            end else if (same_dir && (tgt_mag > cur_mag)) begin
                mode     = ACCEL;
                nxt_sign = tgt_sign;
                nxt_mag  = acc_mag;
            end else if (same_dir) begin
                mode    = DECEL;
                nxt_mag = dec_mag;
            end else if (tgt_mag == '0) begin
                mode    = DECEL;
                nxt_mag = dec_raw;
            end else begin
                mode    = REVERSE;
                nxt_mag = dec_raw;
            end
            w_d     = {nxt_sign & (nxt_mag != '0), nxt_mag};
            state_d = (w_d == tgt_q) ? HOLD : mode;
        end

`ifdef WHEEL_SETPOINT_RAMP_ESTOP_EN
        // Emergency stop overrides everything, every clock
        if (WHEEL_SETPOINT_RAMP_ESTOP_In) begin
            w_d     = '0;
            tgt_d   = '0;
            state_d = HOLD;
        end
`endif
    end

    // State, output and target registers
    always_ff @(posedge WHEEL_SETPOINT_RAMP_CLOCK or negedge WHEEL_SETPOINT_RAMP_RESET_InLow) begin
        if (!WHEEL_SETPOINT_RAMP_RESET_InLow) begin
            state_q <= HOLD;
            w_q     <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            tgt_q   <= tgt_d;
        end
    end

    assign WHEEL_SETPOINT_RAMP_W_OutBus      = w_q;
    assign WHEEL_SETPOINT_RAMP_ATTARGET_Out  = (w_q == tgt_q);
    assign WHEEL_SETPOINT_RAMP_REVERSING_Out = (state_q == REVERSE);

endmodule

// File: tb/tb_wheel_setpoint_ramp.sv
// Directed self-checking bench for wheel_setpoint_ramp.
module tb_wheel_setpoint_ramp;

    logic        clk;
    logic        rst_n;
    logic [16:0] target;
    logic        tv;
    logic [15:0] step;
    logic        tick;
    logic [16:0] w;
    logic        at_target;
    logic        reversing;
`ifdef WHEEL_SETPOINT_RAMP_ESTOP_EN
    logic        estop;
`endif

    int n_pass  = 0;
    int n_total = 0;

    wheel_setpoint_ramp dut (
        .WHEEL_SETPOINT_RAMP_CLOCK          (clk),
        .WHEEL_SETPOINT_RAMP_RESET_InLow    (rst_n),
        .WHEEL_SETPOINT_RAMP_TARGET_InBus   (target),
        .WHEEL_SETPOINT_RAMP_TARGETVALID_In (tv),
        .WHEEL_SETPOINT_RAMP_STEP_InBus     (step),
        .WHEEL_SETPOINT_RAMP_TICK_In        (tick),
`ifdef WHEEL_SETPOINT_RAMP_ESTOP_EN
        .WHEEL_SETPOINT_RAMP_ESTOP_In       (estop),
`endif
        .WHEEL_SETPOINT_RAMP_W_OutBus       (w),
        .WHEEL_SETPOINT_RAMP_ATTARGET_Out   (at_target),
        .WHEEL_SETPOINT_RAMP_REVERSING_Out  (reversing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Checks output word, ATTARGET and REVERSING together
    task automatic check_out(input string tag, input logic [16:0] ew, input logic ea, input logic er);
        check({tag, ".w"}, 32'(w), 32'(ew));
        check({tag, ".at"}, 32'(at_target), 32'(ea));
        check({tag, ".rev"}, 32'(reversing), 32'(er));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [16:0] t);
        target = t;
        tv     = 1'b1;
        cyc();
        tv     = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
    endtask

    initial begin
        rst_n  = 1'b0;
        target = '0;
        tv     = 1'b0;
        step   = '0;
        tick   = 1'b0;
`ifdef WHEEL_SETPOINT_RAMP_ESTOP_EN
        estop  = 1'b0;
`endif
        #12;
        check_out("reset", 17'h00000, 1'b1, 1'b0);
        rst_n = 1'b1;
        cyc();

        // Accelerate from 0 to +10.0 in 0x100 steps, then hold
        step = 16'h0100;
        load(17'h00A00);
        check_out("acc_loaded", 17'h00000, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            do_tick();
            check_out($sformatf("acc_t%0d", k), (k >= 10) ? 17'h00A00 : 17'(k * 16'h0100),
                      (k >= 10), 1'b0);
        end

        // Reverse to -3.0 through +0
        step = 16'h0400;
        load(17'h10300);
        do_tick(); check_out("rev_t1", 17'h00600, 1'b0, 1'b1);
        do_tick(); check_out("rev_t2", 17'h00200, 1'b0, 1'b1);
        do_tick(); check_out("rev_t3", 17'h00000, 1'b0, 1'b1);
        do_tick(); check_out("rev_t4", 17'h10300, 1'b1, 1'b0);
        do_tick(); check_out("rev_t5", 17'h10300, 1'b1, 1'b0);

        // Target +0 from -3.0 is a plain deceleration, no reversal flag
        load(17'h00000);
        do_tick(); check_out("dec_zero", 17'h00000, 1'b1, 1'b0);

        // Step larger than distance: clamp without overshoot
        step = 16'h0300;
        load(17'h00100);
        do_tick(); check_out("no_overshoot", 17'h00100, 1'b1, 1'b0);

        // Reach +2.0, then new target on the same edge as a tick
        step = 16'h0100;
        load(17'h00200);
        do_tick(); check_out("hold2", 17'h00200, 1'b1, 1'b0);
        target = 17'h00500;
        tv     = 1'b1;
        tick   = 1'b1;
        cyc();
        tv     = 1'b0;
        tick   = 1'b0;
        cyc();
        check_out("tv_tick_same", 17'h00200, 1'b0, 1'b0);
        do_tick(); check_out("tv_tick_next", 17'h00300, 1'b0, 1'b0);

        // Oversized negative target clamps to -20.0
        step = 16'h2000;
        load(17'h1FFFF);
        do_tick(); check_out("clamp_t1", 17'h00000, 1'b0, 1'b1);
        do_tick(); check_out("clamp_t2", 17'h11400, 1'b1, 1'b0);

        // Negative zero target is stored as +0
        load(17'h10000);
        check_out("negzero_load", 17'h11400, 1'b0, 1'b0);
        do_tick(); check_out("negzero_t1", 17'h00000, 1'b1, 1'b0);

        // STEP = 0 freezes the output
        step = 16'h0000;
        load(17'h00500);
        do_tick(); check_out("step0", 17'h00000, 1'b0, 1'b0);

        // Decelerate within the same sign
        step = 16'h0500;
        do_tick(); check_out("dec_pre", 17'h00500, 1'b1, 1'b0);
        step = 16'h0300;
        load(17'h00100);
        do_tick(); check_out("dec_t1", 17'h00200, 1'b0, 1'b0);
        do_tick(); check_out("dec_t2", 17'h00100, 1'b1, 1'b0);

        // Ramp to +7.0 and apply reset away from any clock edge
        step = 16'h0100;
        load(17'h00A00);
        for (int k = 0; k < 6; k++) do_tick();
        check_out("pre_reset", 17'h00700, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 17'h00000, 1'b1, 1'b0);
        #2;
        rst_n = 1'b1;
        cyc();
        do_tick(); check_out("post_reset", 17'h00000, 1'b1, 1'b0);

`ifdef WHEEL_SETPOINT_RAMP_ESTOP_EN
        load(17'h00A00);
        for (int k = 0; k < 7; k++) do_tick();
        check_out("pre_estop", 17'h00700, 1'b0, 1'b0);
        estop = 1'b1;
        cyc();
        estop = 1'b0;
        check_out("estop", 17'h00000, 1'b1, 1'b0);
        do_tick(); check_out("estop_after", 17'h00000, 1'b1, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
